// File: rtl/wrong_guess_ctrl_if.sv
// Bundle of round-control and display signals between the game top level and wrong_guess_ctrl.
// The master drives the player inputs; the slave (the controller) drives the LED bar and status flags.
interface wrong_guess_ctrl_if #(
  parameter int MAX_WRONG = 10,
  parameter int LED_W     = 16
);
  localparam int CW = $clog2(MAX_WRONG + 1);

  logic             start;
  logic             guess_valid;
  logic             guess_ok;
  logic [LED_W-1:0] led;
  logic [CW-1:0]    wrong_cnt;
  logic             busy;
  logic             fail;
  logic             win;

  modport master (
    output start, guess_valid, guess_ok,
    input  led, wrong_cnt, busy, fail, win
  );

  modport slave (
    input  start, guess_valid, guess_ok,
    output led, wrong_cnt, busy, fail, win
  );
endinterface

// File: rtl/wrong_guess_ctrl.sv
// Round controller for the guessing game: IDLE/PLAY/WIN/FAIL sequencing, wrong-guess
// counting on guess-strobe rising edges, thermometer LED bar and FAIL blink.
module wrong_guess_ctrl #(
  parameter int MAX_WRONG = 10,
  parameter int LED_W     = 16,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic                clk,
  input  logic                reset,
  wrong_guess_ctrl_if.slave   bus
);
  localparam int CW = $clog2(MAX_WRONG + 1);
  localparam int BW = $clog2(BLINK_DIV);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_WIN, S_FAIL} state_t;

  state_t           r_state, w_stateNext;
  logic             r_guessD;
  logic             w_gEdge;
  logic [CW-1:0]    r_wrongCnt, w_wrongCntNext, w_cntInc;
  logic [LED_W-1:0] r_led, w_ledNext;
  logic [BW-1:0]    r_blinkCnt, w_blinkCntNext;
  logic             r_phase, w_phaseNext;
  logic             r_busy, r_fail, r_win;

  function automatic logic [LED_W-1:0] therm(input logic [CW-1:0] n);
    logic [LED_W-1:0] bar;
    for (int i = 0; i < LED_W; i++) begin
      bar[i] = (i < int'(n));
    end
    return bar;
  endfunction

  assign w_gEdge  = bus.guess_valid & ~r_guessD;
  assign w_cntInc = r_wrongCnt + 1'b1;

  always_comb begin
    w_stateNext    = r_state;
    w_wrongCntNext = r_wrongCnt;
    w_ledNext      = r_led;
    w_blinkCntNext = r_blinkCnt;
    w_phaseNext    = r_phase;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_stateNext    = S_PLAY;
          w_wrongCntNext = '0;
          w_ledNext      = '0;
        end
      end
      S_PLAY: begin
        // A restart takes priority and swallows any guess edge in the same cycle.
        if (bus.start) begin
          w_wrongCntNext = '0;
          w_ledNext      = '0;
        end else if (w_gEdge) begin
          if (bus.guess_ok) begin
            w_stateNext = S_WIN;
          end else begin
            w_wrongCntNext = w_cntInc;
            w_ledNext      = therm(w_cntInc);
            if (w_cntInc == CW'(MAX_WRONG)) begin
              w_stateNext    = S_FAIL;
              w_ledNext      = '1;
              w_blinkCntNext = '0;
              w_phaseNext    = 1'b1;
            end
          end
        end
      end
      S_WIN: begin
        if (bus.start) begin
          w_stateNext    = S_PLAY;
          w_wrongCntNext = '0;
          w_ledNext      = '0;
          w_blinkCntNext = '0;
          w_phaseNext    = 1'b0;
        end
      end
      S_FAIL: begin
        if (bus.start) begin
          w_stateNext    = S_PLAY;
          w_wrongCntNext = '0;
          w_ledNext      = '0;
          w_blinkCntNext = '0;
          w_phaseNext    = 1'b0;
        end else if (r_blinkCnt == BW'(BLINK_DIV - 1)) begin
          w_blinkCntNext = '0;
          w_phaseNext    = ~r_phase;
          w_ledNext      = r_phase ? '0 : '1;
        end else begin
          w_blinkCntNext = r_blinkCnt + 1'b1;
        end
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  // Status flags are registered from the next state so they stay one-hot and glitch-free.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_guessD   <= 1'b0;
      r_wrongCnt <= '0;
      r_led      <= '0;
      r_blinkCnt <= '0;
      r_phase    <= 1'b0;
      r_busy     <= 1'b0;
      r_fail     <= 1'b0;
      r_win      <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_guessD   <= bus.guess_valid;
      r_wrongCnt <= w_wrongCntNext;
      r_led      <= w_ledNext;
      r_blinkCnt <= w_blinkCntNext;
      r_phase    <= w_phaseNext;
      r_busy     <= (w_stateNext == S_PLAY);
      r_fail     <= (w_stateNext == S_FAIL);
      r_win      <= (w_stateNext == S_WIN);
    end
  end

  assign bus.led       = r_led;
  assign bus.wrong_cnt = r_wrongCnt;
  assign bus.busy      = r_busy;
  assign bus.fail      = r_fail;
  assign bus.win       = r_win;
endmodule

// File: tb/tb_wrong_guess_ctrl.sv
// Scoreboard bench for wrong_guess_ctrl: a round-level reference model predicts the outputs
// after every clock edge; a monitor pops and compares them one step after each rising edge.
module tb_wrong_guess_ctrl;
  localparam int MAX_WRONG = 10;
  localparam int LED_W     = 16;
  localparam int BLINK_DIV = 4;
  localparam int CW        = $clog2(MAX_WRONG + 1);

  typedef struct packed {
    logic [LED_W-1:0] led;
    logic [CW-1:0]    cnt;
    logic             busy;
    logic             fail;
    logic             win;
  } outs_t;

  logic clk;
  logic reset;
  wrong_guess_ctrl_if #(.MAX_WRONG(MAX_WRONG), .LED_W(LED_W)) bus ();

  wrong_guess_ctrl #(
    .MAX_WRONG(MAX_WRONG),
    .LED_W    (LED_W),
    .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  outs_t expQ[$];
  int    nCompared   = 0;
  int    nMismatched = 0;

  // Reference model: round mode, wrong count, previous strobe level and cycles spent in FAIL.
  typedef enum {M_IDLE, M_PLAY, M_WIN, M_FAIL} mode_t;
  mode_t            mMode   = M_IDLE;
  int               mWrongs = 0;
  int               mAge    = 0;
  bit               mPrev   = 1'b0;
  logic [LED_W-1:0] mLed    = '0;

  function automatic logic [LED_W-1:0] barOf(int n);
    longint v;
    v = (longint'(1) << n) - 1;
    return LED_W'(v);
  endfunction

  task automatic modelStep(input bit rst_n, input bit st, input bit gv, input bit ok);
    bit edgeSeen;
    outs_t e;
    if (!rst_n) begin
      mMode = M_IDLE; mWrongs = 0; mAge = 0; mPrev = 1'b0; mLed = '0;
    end else begin
      edgeSeen = gv && !mPrev;
      mPrev = gv;
      case (mMode)
        M_IDLE: if (st) begin mMode = M_PLAY; mWrongs = 0; mLed = '0; end
        M_PLAY: begin
          if (st) begin
            mWrongs = 0; mLed = '0;
          end else if (edgeSeen) begin
            if (ok) mMode = M_WIN;
            else begin
              mWrongs++;
              if (mWrongs == MAX_WRONG) begin
                mMode = M_FAIL; mAge = 0; mLed = '1;
              end else begin
                mLed = barOf(mWrongs);
              end
            end
          end
        end
        M_WIN: if (st) begin mMode = M_PLAY; mWrongs = 0; mLed = '0; end
        M_FAIL: begin
          if (st) begin
            mMode = M_PLAY; mWrongs = 0; mLed = '0;
          end else begin
            mAge++;
            mLed = ((mAge / BLINK_DIV) % 2 == 0) ? '1 : '0;
          end
        end
      endcase
    end
    e.led  = mLed;
    e.cnt  = CW'(mWrongs);
    e.busy = (mMode == M_PLAY);
    e.fail = (mMode == M_FAIL);
    e.win  = (mMode == M_WIN);
    expQ.push_back(e);
  endtask

  // Drive one input pattern for n cycles; each cycle's expected result goes to the scoreboard.
  task automatic applyStimulus(input bit rst_n, input bit st, input bit gv, input bit ok, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset = rst_n;
      bus.start = st;
      bus.guess_valid = gv;
      bus.guess_ok = ok;
      modelStep(rst_n, st, gv, ok);
    end
  endtask

  task automatic strobe(input bit ok);
    applyStimulus(1'b1, 1'b0, 1'b1, ok, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2);
  endtask

  task automatic checkOutput(input outs_t exp);
    outs_t act;
    act.led  = bus.led;
    act.cnt  = bus.wrong_cnt;
    act.busy = bus.busy;
    act.fail = bus.fail;
    act.win  = bus.win;
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL outputs @%0t: got led=%h cnt=%0d busy=%b fail=%b win=%b, expected led=%h cnt=%0d busy=%b fail=%b win=%b",
               $time, act.led, act.cnt, act.busy, act.fail, act.win,
               exp.led, exp.cnt, exp.busy, exp.fail, exp.win);
    end
  endtask

  // Monitor: the controller presents a fresh output set after every rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    bus.start = 1'b0;
    bus.guess_valid = 1'b0;
    bus.guess_ok = 1'b0;

    // Reset dominates start and strobe.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);

    // Start, then three wrong strobes.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);
    for (int i = 0; i < 3; i++) strobe(1'b0);

    // Held strobe counts once.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 5);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2);

    // Restart, ten wrong strobes into FAIL, watch the blink, extra strobe ignored.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1);
    for (int i = 0; i < MAX_WRONG; i++) strobe(1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 10);
    strobe(1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3);

    // Reset in the middle of the blink.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);

    // Two wrong then a correct guess; later strobes ignored; restart.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1);
    strobe(1'b0);
    strobe(1'b0);
    strobe(1'b1);
    strobe(1'b0);
    strobe(1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);

    // Start coincident with a wrong edge drops the guess.
    strobe(1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2);

    // Randomized traffic; wrong guesses dominate so FAIL is reached regularly.
    for (int i = 0; i < 2000; i++) begin
      applyStimulus(($urandom_range(0, 199) != 0),
                    ($urandom_range(0, 39) == 0),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0), 1);
    end

    @(posedge clk);
    #2;
    nCompared++;
    if (expQ.size() != 0) begin
      nMismatched++;
      $display("[TB] FAIL drain: %0d expected entries left, expected 0", expQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
